pop_rank_sorter: RTL

Parametrised ranking engine for the genetic-algorithm population. It captures N unsigned fitness/distance keys on `start` and emits member indices in rank order, one per cycle, over a valid/ready stream. It also builds a registered rank table for the selection and crossover stages. Over the previous fixed 50×12-bit sorter it adds:
- configurable size;
- ascending/descending mode;
- top-K early termination;
- output backpressure;
- a deterministic tie rule.

---
 rtl/pop_sort_pkg.sv | 19 +
 rtl/pop_best_select.sv | 48 ++++
 rtl/pop_rank_sorter.sv | 106 ++++++++++
 3 files changed

// File: rtl/pop_sort_pkg.sv
// Shared types and helpers for the population ranking engine.
package pop_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } pop_state_e;

  localparam int unsigned POP_N     = 50;
  localparam int unsigned POP_KEY_W = 12;

  // A zero or oversized request means "rank the whole population".
  function automatic int unsigned pop_clamp_k(input int unsigned k, input int unsigned n);
    if (k == 0 || k > n) return n;
    return k;
  endfunction

endpackage

// File: rtl/pop_best_select.sv
// Combinational best-of-N reduction over unused entries; ties go to the lowest index.
module pop_best_select #(
  parameter int unsigned N     = 50,
  parameter int unsigned KEY_W = 12,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N*KEY_W-1:0] i_keys,
  input  logic [N-1:0]       i_used,
  input  logic               i_descending,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  localparam int unsigned P = 1 << $clog2(N);

  // Heap-indexed tournament tree: node j merges children 2j (lower indices) and 2j+1.
  logic [KEY_W-1:0] w_key [2*P];
  logic [IDX_W-1:0] w_idx [2*P];
  logic             w_vld [2*P];
  logic             w_take_r;

  always_comb begin
    w_take_r = 1'b0;
    for (int unsigned j = 0; j < 2 * P; j++) begin
      w_key[j] = '0;
      w_idx[j] = '0;
      w_vld[j] = 1'b0;
    end
    for (int unsigned i = 0; i < N; i++) begin
      w_key[P+i] = i_keys[i*KEY_W +: KEY_W];
      w_idx[P+i] = IDX_W'(i);
      w_vld[P+i] = !i_used[i];
    end
    for (int j = int'(P) - 1; j >= 1; j--) begin
      // Strict compare keeps the left (lower-index) child on equal keys.
      w_take_r = w_vld[2*j+1] &&
                 (!w_vld[2*j] ||
                  (i_descending ? (w_key[2*j+1] > w_key[2*j]) : (w_key[2*j+1] < w_key[2*j])));
      w_key[j] = w_take_r ? w_key[2*j+1] : w_key[2*j];
      w_idx[j] = w_take_r ? w_idx[2*j+1] : w_idx[2*j];
      w_vld[j] = w_vld[2*j] || w_vld[2*j+1];
    end
  end

  assign o_idx   = w_idx[1];
  assign o_found = w_vld[1];

endmodule

// File: rtl/pop_rank_sorter.sv
// Ranking engine: captures N keys on start and streams member indices in rank order,
// building a registered rank table alongside.
module pop_rank_sorter
  import pop_sort_pkg::*;
#(
  parameter int unsigned N     = POP_N,
  parameter int unsigned KEY_W = POP_KEY_W,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*KEY_W-1:0] keys,
  input  logic               descending,
  input  logic [IDX_W:0]     k_limit,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [IDX_W-1:0]   out_rank,
  output logic [N*IDX_W-1:0] sorted_idx
);

  pop_state_e         r_state;
  logic [N*KEY_W-1:0] r_keys;
  logic [N-1:0]       r_used;
  logic [IDX_W:0]     r_cnt;
  logic [IDX_W:0]     r_k;
  logic               r_desc;
  logic               r_out_valid;
  logic [IDX_W-1:0]   r_out_idx;
  logic [IDX_W-1:0]   r_out_rank;
  logic [IDX_W-1:0]   r_table [N];

  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic               w_start_ok;
  logic               w_emit;
  logic               w_last_acc;

  pop_best_select #(
    .N     (N),
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_select (
    .i_keys       (r_keys),
    .i_used       (r_used),
    .i_descending (r_desc),
    .o_idx        (w_win),
    .o_found      (w_found)
  );

  assign w_start_ok = start && (r_state != ST_SORT);
  assign w_emit     = (r_state == ST_SORT) && (!r_out_valid || out_ready) &&
                      (r_cnt < r_k) && w_found;
  // Counter already at K means the word on display is the final rank.
  assign w_last_acc = (r_state == ST_SORT) && r_out_valid && out_ready && (r_cnt == r_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_keys      <= '0;
      r_used      <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_desc      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_rank  <= '0;
      for (int unsigned r = 0; r < N; r++) r_table[r] <= '0;
    end else if (w_start_ok) begin
      r_state     <= ST_SORT;
      r_keys      <= keys;
      r_used      <= '0;
      r_cnt       <= '0;
      r_desc      <= descending;
      r_k         <= (IDX_W+1)'(pop_clamp_k(32'(k_limit), N));
      r_out_valid <= 1'b0;
      for (int unsigned r = 0; r < N; r++) r_table[r] <= '0;
    end else if (r_state == ST_SORT) begin
      if (w_emit) begin
        r_used[w_win]               <= 1'b1;
        r_out_idx                   <= w_win;
        r_out_rank                  <= r_cnt[IDX_W-1:0];
        r_table[r_cnt[IDX_W-1:0]]   <= w_win;
        r_cnt                       <= r_cnt + (IDX_W+1)'(1);
        r_out_valid                 <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_last_acc) r_state <= ST_DONE;
    end
  end

  assign busy      = (r_state == ST_SORT);
  assign done      = (r_state == ST_DONE);
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_rank  = r_out_rank;

  for (genvar g = 0; g < N; g++) begin : g_table
    assign sorted_idx[g*IDX_W +: IDX_W] = r_table[g];
  end

endmodule
